// File: rtl/efpga_mac_pipe.sv
// Parametrised multiply-accumulate DSP primitive for the eFPGA fabric.
// Optional input/product pipeline stages, a registered P stage, and wrap or saturate.
module efpga_mac_pipe #(
    parameter int A_WIDTH  = 18,
    parameter int B_WIDTH  = 18,
    parameter int P_WIDTH  = 40,
    parameter int SIGNED   = 1,
    parameter int REG_IN   = 1,
    parameter int REG_M    = 1,
    parameter int SATURATE = 0
) (
    input  logic               CLK,
    input  logic               SRST,
    input  logic               CE,
    input  logic [A_WIDTH-1:0] A,
    input  logic [B_WIDTH-1:0] B,
    input  logic [P_WIDTH-1:0] C,
    input  logic [1:0]         OPMODE,
    input  logic               IN_VALID,
    output logic [P_WIDTH-1:0] P,
    output logic               P_VALID,
    output logic               OVF
);

    localparam int AB  = A_WIDTH + B_WIDTH;
    localparam bit SGN = (SIGNED != 0);
    localparam bit SAT = (SATURATE != 0);

    generate
        if (P_WIDTH < AB) begin : g_bad_width
            $error("efpga_mac_pipe: P_WIDTH must be >= A_WIDTH+B_WIDTH");
        end
    endgenerate

    logic [A_WIDTH-1:0] a_s1;
    logic [B_WIDTH-1:0] b_s1;
    logic [1:0]         op_s1;
    logic               v_s1;

    generate
        if (REG_IN != 0) begin : g_in_reg
            logic [A_WIDTH-1:0] a_s1_q;
            logic [B_WIDTH-1:0] b_s1_q;
            logic [1:0]         op_s1_q;
            logic               v_s1_q;

            always_ff @(posedge CLK) begin
                if (SRST) begin
                    a_s1_q  <= '0;
                    b_s1_q  <= '0;
                    op_s1_q <= '0;
                    v_s1_q  <= 1'b0;
                end else if (CE) begin
                    a_s1_q  <= A;
                    b_s1_q  <= B;
                    op_s1_q <= OPMODE;
                    v_s1_q  <= IN_VALID;
                end
            end

            assign a_s1  = a_s1_q;
            assign b_s1  = b_s1_q;
            assign op_s1 = op_s1_q;
            assign v_s1  = v_s1_q;
        end else begin : g_in_byp
            assign a_s1  = A;
            assign b_s1  = B;
            assign op_s1 = OPMODE;
            assign v_s1  = IN_VALID;
        end
    endgenerate

    // Extending both operands to AB bits makes one unsigned multiply exact for either signedness.
    logic [AB-1:0] a_x;
    logic [AB-1:0] b_x;
    logic [AB-1:0] prod_s1;

    assign a_x     = {{B_WIDTH{SGN & a_s1[A_WIDTH-1]}}, a_s1};
    assign b_x     = {{A_WIDTH{SGN & b_s1[B_WIDTH-1]}}, b_s1};
    assign prod_s1 = a_x * b_x;

    logic [AB-1:0] prod_s2;
    logic [1:0]    op_s2;
    logic          v_s2;

    generate
        if (REG_M != 0) begin : g_m_reg
            logic [AB-1:0] prod_s2_q;
            logic [1:0]    op_s2_q;
            logic          v_s2_q;

            always_ff @(posedge CLK) begin
                if (SRST) begin
                    prod_s2_q <= '0;
                    op_s2_q   <= '0;
                    v_s2_q    <= 1'b0;
                end else if (CE) begin
                    prod_s2_q <= prod_s1;
                    op_s2_q   <= op_s1;
                    v_s2_q    <= v_s1;
                end
            end

            assign prod_s2 = prod_s2_q;
            assign op_s2   = op_s2_q;
            assign v_s2    = v_s2_q;
        end else begin : g_m_byp
            assign prod_s2 = prod_s1;
            assign op_s2   = op_s1;
            assign v_s2    = v_s1;
        end
    endgenerate

    logic [P_WIDTH-1:0] p_q;
    logic [P_WIDTH-1:0] p_d;
    logic               pv_q;
    logic               ovf_q;
    logic               ovf_d;
    logic [P_WIDTH:0]   prod_x;
    logic [P_WIDTH:0]   p_x;
    logic [P_WIDTH:0]   c_x;
    logic [P_WIDTH:0]   sum;
    logic [P_WIDTH-1:0] sat_val;

    assign prod_x = {{(P_WIDTH + 1 - AB){SGN & prod_s2[AB-1]}}, prod_s2};
    assign p_x    = {SGN & p_q[P_WIDTH-1], p_q};
    assign c_x    = {SGN & C[P_WIDTH-1], C};

    always_comb begin
        sum     = prod_x;
        sat_val = '0;
        ovf_d   = 1'b0;
        p_d     = p_q;
        unique case (op_s2)
            2'b00: sum = prod_x;
            2'b01: sum = p_x + prod_x;
            2'b10: sum = p_x - prod_x;
            2'b11: sum = c_x + prod_x;
        endcase
        if (op_s2 != 2'b00) begin
            if (SGN) ovf_d = sum[P_WIDTH] ^ sum[P_WIDTH-1];
            else     ovf_d = sum[P_WIDTH];
        end
        // Unsigned overflow direction follows the op: only subtract can underflow.
        if (SGN) begin
            sat_val = sum[P_WIDTH] ? {1'b1, {(P_WIDTH-1){1'b0}}}
                                   : {1'b0, {(P_WIDTH-1){1'b1}}};
        end else begin
            sat_val = (op_s2 == 2'b10) ? '0 : '1;
        end
        if (SAT && ovf_d) p_d = sat_val;
        else              p_d = sum[P_WIDTH-1:0];
    end

    always_ff @(posedge CLK) begin
        if (SRST) begin
            p_q   <= '0;
            pv_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else if (CE) begin
            pv_q <= v_s2;
            if (v_s2) begin
                p_q   <= p_d;
                ovf_q <= ovf_d;
            end
        end
    end

    assign P       = p_q;
    assign P_VALID = pv_q;
    assign OVF     = ovf_q;

endmodule

// File: tb/tb_efpga_mac_pipe.sv
// Bench for efpga_mac_pipe: three configurations share one stimulus stream,
// each compared every cycle against an arithmetic reference model.
module tb_efpga_mac_pipe;

    logic        CLK = 1'b0;
    logic        SRST;
    logic        CE;
    logic [17:0] A;
    logic [17:0] B;
    logic [39:0] C;
    logic [1:0]  OPMODE;
    logic        IN_VALID;

    logic [39:0] p0, p1, p2;
    logic        pv0, pv1, pv2;
    logic        ov0, ov1, ov2;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    // u_dut: signed, wrap, L=3
    efpga_mac_pipe u_dut (
        .CLK(CLK), .SRST(SRST), .CE(CE), .A(A), .B(B), .C(C),
        .OPMODE(OPMODE), .IN_VALID(IN_VALID),
        .P(p0), .P_VALID(pv0), .OVF(ov0)
    );

    // u_sat: signed, saturating, L=3
    efpga_mac_pipe #(.SATURATE(1)) u_sat (
        .CLK(CLK), .SRST(SRST), .CE(CE), .A(A), .B(B), .C(C),
        .OPMODE(OPMODE), .IN_VALID(IN_VALID),
        .P(p1), .P_VALID(pv1), .OVF(ov1)
    );

    // u_unr: unsigned, wrap, L=1
    efpga_mac_pipe #(.REG_IN(0), .REG_M(0), .SIGNED(0)) u_unr (
        .CLK(CLK), .SRST(SRST), .CE(CE), .A(A), .B(B), .C(C),
        .OPMODE(OPMODE), .IN_VALID(IN_VALID),
        .P(p2), .P_VALID(pv2), .OVF(ov2)
    );

    typedef struct packed {
        logic        v;
        logic [1:0]  op;
        logic [17:0] a;
        logic [17:0] b;
    } op_t;

    // Inputs seen on each enabled edge; a DUT of latency L applies the one from L-1 edges back.
    op_t    hist[$];
    longint mp[3];
    bit     mv[3];
    bit     mo[3];
    bit     msgn[3] = '{1'b1, 1'b1, 1'b0};
    bit     msat[3] = '{1'b0, 1'b1, 1'b0};
    int     mlat[3] = '{3, 3, 1};

    function automatic longint ival(longint x, int w, bit s);
        longint m;
        longint v;
        m = (64'sd1 <<< w) - 1;
        v = x & m;
        if (s && v[w-1]) v = v - (64'sd1 <<< w);
        return v;
    endfunction

    task automatic model_edge();
        op_t    cur;
        op_t    e;
        longint prod, sum, lo, hi;
        bit     s, o;
        if (SRST) begin
            hist.delete();
            hist.push_back('0);
            hist.push_back('0);
            for (int k = 0; k < 3; k++) begin
                mp[k] = 0;
                mv[k] = 1'b0;
                mo[k] = 1'b0;
            end
        end else if (CE) begin
            cur = '{IN_VALID, OPMODE, A, B};
            hist.push_back(cur);
            for (int k = 0; k < 3; k++) begin
                e = hist[hist.size() - mlat[k]];
                s = msgn[k];
                mv[k] = e.v;
                if (e.v) begin
                    prod = ival(longint'(e.a), 18, s) * ival(longint'(e.b), 18, s);
                    case (e.op)
                        2'd0:    sum = prod;
                        2'd1:    sum = mp[k] + prod;
                        2'd2:    sum = mp[k] - prod;
                        default: sum = ival(longint'(C), 40, s) + prod;
                    endcase
                    hi = s ? (64'sd1 <<< 39) - 1 : (64'sd1 <<< 40) - 1;
                    lo = s ? -(64'sd1 <<< 39) : 64'sd0;
                    o = (e.op != 2'd0) && (sum < lo || sum > hi);
                    mo[k] = o;
                    if (!o)          mp[k] = sum;
                    else if (msat[k]) mp[k] = (sum > hi) ? hi : lo;
                    else             mp[k] = ival(sum, 40, s);
                end
            end
            while (hist.size() > 2) void'(hist.pop_front());
        end
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [39:0] op;
        logic        ov, ovv;
        longint      m;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0:       begin op = p0; ov = pv0; ovv = ov0; end
                1:       begin op = p1; ov = pv1; ovv = ov1; end
                default: begin op = p2; ov = pv2; ovv = ov2; end
            endcase
            m = mp[k];
            chk($sformatf("model_P[%0d]", k), {24'd0, op}, {24'd0, m[39:0]});
            chk($sformatf("model_PV[%0d]", k), {63'd0, ov}, {63'd0, mv[k]});
            chk($sformatf("model_OVF[%0d]", k), {63'd0, ovv}, {63'd0, mo[k]});
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(logic v, logic [1:0] op, logic [17:0] a, logic [17:0] b);
        IN_VALID = v;
        OPMODE   = op;
        A        = a;
        B        = b;
    endtask

    task automatic do_reset();
        SRST = 1'b1;
        CE   = 1'b1;
        drive(1'b0, 2'd0, 18'd0, 18'd0);
        cycle();
        SRST = 1'b0;
    endtask

    initial begin
        C = '0;
        do_reset();
        chk("reset_P", {24'd0, p0}, 64'd0);
        chk("reset_PV", {63'd0, pv0}, 64'd0);
        chk("reset_OVF", {63'd0, ov0}, 64'd0);

        // T1: single signed multiply, latency 3
        drive(1'b1, 2'd0, 18'd3, 18'(-5));
        cycle();
        drive(1'b0, 2'd0, 18'd0, 18'd0);
        cycle();
        cycle();
        chk("T1_P", {24'd0, p0}, {24'd0, 40'(-15)});
        chk("T1_PV", {63'd0, pv0}, 64'd1);
        chk("T1_OVF", {63'd0, ov0}, 64'd0);
        cycle();
        chk("T1_PV_drop", {63'd0, pv0}, 64'd0);

        // T2: back-to-back accumulate, no bubbles
        do_reset();
        drive(1'b1, 2'd1, 18'd1000, 18'd1000);
        for (int i = 0; i < 6; i++) begin
            if (i == 4) drive(1'b0, 2'd0, 18'd0, 18'd0);
            cycle();
            if (i >= 2) begin
                chk("T2_P", {24'd0, p0}, 64'(1000000 * (i - 1)));
                chk("T2_PV", {63'd0, pv0}, 64'd1);
            end
        end

        // T3: preload near max then accumulate past it
        do_reset();
        C = 40'h7F_FFFF_FFF6;
        drive(1'b1, 2'd3, 18'd0, 18'd0);
        cycle();
        drive(1'b1, 2'd1, 18'd4, 18'd4);
        cycle();
        drive(1'b0, 2'd0, 18'd0, 18'd0);
        cycle();
        chk("T3_preload", {24'd0, p1}, 64'h7F_FFFF_FFF6);
        cycle();
        chk("T3_sat_P", {24'd0, p1}, 64'h7F_FFFF_FFFF);
        chk("T3_sat_OVF", {63'd0, ov1}, 64'd1);
        chk("T3_wrap_P", {24'd0, p0}, 64'h80_0000_0006);
        chk("T3_wrap_OVF", {63'd0, ov0}, 64'd1);
        C = '0;

        // T4: stall mid-pipeline
        do_reset();
        drive(1'b1, 2'd0, 18'd7, 18'd9);
        cycle();
        drive(1'b0, 2'd0, 18'd0, 18'd0);
        CE = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("T4_stall_PV", {63'd0, pv0}, 64'd0);
            chk("T4_stall_P", {24'd0, p0}, 64'd0);
        end
        CE = 1'b1;
        cycle();
        cycle();
        chk("T4_P", {24'd0, p0}, 64'd63);
        chk("T4_PV", {63'd0, pv0}, 64'd1);

        // T5: reset behind an in-flight op
        do_reset();
        drive(1'b1, 2'd0, 18'd5, 18'd5);
        cycle();
        drive(1'b0, 2'd0, 18'd0, 18'd0);
        SRST = 1'b1;
        cycle();
        SRST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("T5_PV", {63'd0, pv0}, 64'd0);
            chk("T5_P", {24'd0, p0}, 64'd0);
        end
        drive(1'b1, 2'd1, 18'd2, 18'd3);
        cycle();
        drive(1'b0, 2'd0, 18'd0, 18'd0);
        cycle();
        cycle();
        chk("T5_after", {24'd0, p0}, 64'd6);

        // Reset dominates a valid op and CE=0
        SRST = 1'b1;
        CE   = 1'b0;
        drive(1'b1, 2'd0, 18'd9, 18'd9);
        cycle();
        chk("rst_vs_valid_P", {24'd0, p2}, 64'd0);
        chk("rst_vs_valid_PV", {63'd0, pv2}, 64'd0);
        SRST = 1'b0;
        CE   = 1'b1;

        // T6: unregistered unsigned full-scale product
        do_reset();
        drive(1'b1, 2'd0, 18'h3FFFF, 18'h3FFFF);
        cycle();
        chk("T6_P", {24'd0, p2}, 64'h0F_FFF8_0001);
        chk("T6_PV", {63'd0, pv2}, 64'd1);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            SRST = ($urandom_range(63) == 0);
            CE   = ($urandom_range(7) != 0);
            drive(1'($urandom), 2'($urandom), 18'($urandom), 18'($urandom));
            case ($urandom_range(3))
                0:       C = {8'($urandom), 32'($urandom)};
                1:       C = 40'h7F_FFF0_0000 + 40'($urandom_range(1 << 20));
                2:       C = 40'h80_0000_0000 + 40'($urandom_range(1 << 20));
                default: C = 40'hFF_FFF0_0000 + 40'($urandom_range(1 << 20));
            endcase
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
